// File: rtl/sprite_list_writer.sv
// sprite_list_writer
//   Writer side of the sprite RAM. It takes whole sprite records over a
//   valid/ready stream and writes each one as four bytes: VPOS, IDX, EXT,
//   HPOS. When the list ends, it blanks every remaining slot (BLANK_VPOS, 0,
//   0, 0). Bytes are written only while wr_window is open.
//
//   Ports
//     master_clk, reset      : clock, synchronous active-high reset
//     frame_start            : restart the list (aborts any record in flight)
//     list_end               : list complete, blank the remaining slots
//     wr_window              : sprite RAM may be written this cycle
//     in_valid / in_ready    : record handshake
//     in_vpos/idx/ext/hpos   : record fields
//     spr_addr/data/we       : sprite RAM CPU-side byte write port
//     sprite_count           : records written since frame_start
//     busy                   : registered, high while writing or clearing
//     overflow               : sticky, record offered while list full
module sprite_list_writer #(
    parameter logic [10:0] BASE_ADDR  = 11'h000,
    parameter int          N_SPRITES  = 128,
    parameter logic [7:0]  BLANK_VPOS = 8'hF8
) (
    input  logic        master_clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        list_end,
    input  logic        wr_window,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_vpos,
    input  logic [7:0]  in_idx,
    input  logic [7:0]  in_ext,
    input  logic [7:0]  in_hpos,
    output logic [10:0] spr_addr,
    output logic [7:0]  spr_data,
    output logic        spr_we,
    output logic [9:0]  sprite_count,
    output logic        busy,
    output logic        overflow
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_CLEAR, S_DONE} state_t;

    localparam logic [9:0] N_CNT     = 10'(N_SPRITES);
    localparam logic [9:0] LAST_SLOT = 10'(N_SPRITES - 1);

    state_t          state, next_state;
    logic [3:0][7:0] rec;          // [0]=VPOS [1]=IDX [2]=EXT [3]=HPOS
    logic [1:0]      byte_idx;
    logic [9:0]      clr_slot;
    logic            pend_end;
    logic [10:0]     last_addr, cur_addr;
    logic [7:0]      last_data, cur_data;
    logic [9:0]      cur_slot;

    logic list_full, hs, accept, discard, last_byte, end_req;

    assign list_full = (sprite_count == N_CNT);
    assign hs        = in_valid & in_ready;
    assign accept    = hs & ~list_full;
    // A record offered to a full list is handshaken and thrown away.
    assign discard   = hs & list_full;
    assign last_byte = spr_we & (byte_idx == 2'd3);
    assign end_req   = list_end | pend_end;

    // State register
    always_ff @(posedge master_clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept)       next_state = S_WRITE;
                else if (end_req) next_state = list_full ? S_DONE : S_CLEAR;
            end
            S_WRITE: begin
                // A pending end goes straight to CLEAR after the last byte.
                if (last_byte && end_req)
                    next_state = (sprite_count == LAST_SLOT) ? S_DONE : S_CLEAR;
                else if (last_byte)
                    next_state = S_IDLE;
            end
            S_CLEAR: begin
                if (last_byte && clr_slot == LAST_SLOT) next_state = S_DONE;
            end
            S_DONE:  next_state = S_DONE;
            default: next_state = S_IDLE;
        endcase
        if (frame_start) next_state = S_IDLE;
    end

    // Outputs: strobes are combinational gates on the registered state so a
    // closing window stops the write in the same cycle.
    always_comb begin
        in_ready = ~reset & ~frame_start & (state == S_IDLE) & wr_window &
                   (~list_full | in_valid);
        spr_we   = ~reset & ~frame_start & wr_window &
                   ((state == S_WRITE) | (state == S_CLEAR));
        cur_slot = (state == S_CLEAR) ? clr_slot : sprite_count;
        cur_addr = BASE_ADDR + {cur_slot[8:0], 2'b00} + {9'd0, byte_idx};
        if (state == S_CLEAR) cur_data = (byte_idx == 2'd0) ? BLANK_VPOS : 8'h00;
        else                  cur_data = rec[byte_idx];
        spr_addr = spr_we ? cur_addr : last_addr;
        spr_data = spr_we ? cur_data : last_data;
    end

    // Datapath
    always_ff @(posedge master_clk) begin
        if (reset) begin
            sprite_count <= '0;
            overflow     <= 1'b0;
            pend_end     <= 1'b0;
            byte_idx     <= '0;
            clr_slot     <= '0;
            rec          <= '0;
            busy         <= 1'b0;
            last_addr    <= BASE_ADDR;
            last_data    <= 8'h00;
        end else begin
            busy <= (next_state == S_WRITE) | (next_state == S_CLEAR);
            if (spr_we) begin
                last_addr <= cur_addr;
                last_data <= cur_data;
            end
            if (frame_start) begin
                sprite_count <= '0;
                overflow     <= 1'b0;
                pend_end     <= 1'b0;
                byte_idx     <= '0;
            end else begin
                if (accept) begin
                    rec      <= {in_hpos, in_ext, in_idx, in_vpos};
                    byte_idx <= '0;
                end
                if (discard) overflow <= 1'b1;
                if (spr_we)  byte_idx <= byte_idx + 2'd1;
                if (state == S_WRITE && last_byte) sprite_count <= sprite_count + 10'd1;
                if (state == S_CLEAR && last_byte) clr_slot <= clr_slot + 10'd1;
                // Blanking starts at the first unused slot; from WRITE the
                // count has not yet been bumped for the record just finished.
                if (state != S_CLEAR && next_state == S_CLEAR) begin
                    clr_slot <= (state == S_WRITE) ? sprite_count + 10'd1 : sprite_count;
                    byte_idx <= '0;
                end
                if ((next_state == S_CLEAR || next_state == S_DONE) &&
                    state != S_CLEAR && state != S_DONE)
                    pend_end <= 1'b0;
                else if (list_end && (state == S_WRITE || accept))
                    pend_end <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sprite_list_writer.sv
// Testbench for sprite_list_writer. Expected byte writes are produced by a
// list-level model (slot number * 4 + byte) and queued; a monitor pops them
// as the DUT strobes spr_we. A second small instance (2 slots, base near the
// top of RAM) covers overflow and address wrap.
module tb_sprite_list_writer;
    localparam int N = 128;

    logic        master_clk = 1'b0, reset = 1'b1;
    logic        frame_start = 1'b0, list_end = 1'b0, wr_window = 1'b0, in_valid = 1'b0;
    logic [7:0]  in_vpos = '0, in_idx = '0, in_ext = '0, in_hpos = '0;
    logic        in_ready, spr_we, busy, overflow;
    logic [10:0] spr_addr;
    logic [7:0]  spr_data;
    logic [9:0]  sprite_count;

    logic        b_fs = 1'b0, b_valid = 1'b0;
    logic        b_ready, b_we, b_busy, b_ovf;
    logic [10:0] b_addr;
    logic [7:0]  b_data;
    logic [9:0]  b_count;

    sprite_list_writer dut (
        .master_clk(master_clk), .reset(reset), .frame_start(frame_start),
        .list_end(list_end), .wr_window(wr_window), .in_valid(in_valid),
        .in_ready(in_ready), .in_vpos(in_vpos), .in_idx(in_idx), .in_ext(in_ext),
        .in_hpos(in_hpos), .spr_addr(spr_addr), .spr_data(spr_data), .spr_we(spr_we),
        .sprite_count(sprite_count), .busy(busy), .overflow(overflow));

    sprite_list_writer #(.BASE_ADDR(11'h7FC), .N_SPRITES(2), .BLANK_VPOS(8'hF8)) dut_b (
        .master_clk(master_clk), .reset(reset), .frame_start(b_fs),
        .list_end(1'b0), .wr_window(1'b1), .in_valid(b_valid),
        .in_ready(b_ready), .in_vpos(in_vpos), .in_idx(in_idx), .in_ext(in_ext),
        .in_hpos(in_hpos), .spr_addr(b_addr), .spr_data(b_data), .spr_we(b_we),
        .sprite_count(b_count), .busy(b_busy), .overflow(b_ovf));

    always #5 master_clk = ~master_clk;

    int          n_cmp = 0, n_bad = 0;
    logic [18:0] exp_q[$];
    logic [18:0] obs_b[$];
    logic [18:0] last_wr = '0;
    int          mcount = 0;
    bit          mdone = 0, movf = 0, hs = 0, rnd_win = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] waddr(input int slot, input int b);
        return 11'((slot * 4 + b) % 2048);
    endfunction

    // Monitor: every strobed write must be the next expected one; with the
    // strobe low the port must hold the last written address/data.
    always @(negedge master_clk) begin
        if (!reset) begin
            if (spr_we) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_write: got %0h:%0h expected none (t=%0t)",
                             spr_addr, spr_data, $time);
                end else begin
                    chk("write", int'({spr_addr, spr_data}), int'(exp_q.pop_front()));
                end
                last_wr = {spr_addr, spr_data};
            end else begin
                chk("hold", int'({spr_addr, spr_data}), int'(last_wr));
            end
        end
    end

    always @(negedge master_clk) if (!reset && b_we) obs_b.push_back({b_addr, b_data});

    // One clock: update the list model from what the DUT sees this cycle,
    // then retire pulses and (optionally) randomise the write window.
    task automatic step();
        @(negedge master_clk);
        hs = in_valid && in_ready;
        if (frame_start) begin
            exp_q.delete(); mcount = 0; movf = 0; mdone = 0;
        end else begin
            if (hs) begin
                if (mdone) begin
                    n_cmp++; n_bad++;
                    $display("FAIL accept_after_end: got handshake expected none (t=%0t)", $time);
                end else if (mcount < N) begin
                    exp_q.push_back({waddr(mcount, 0), in_vpos});
                    exp_q.push_back({waddr(mcount, 1), in_idx});
                    exp_q.push_back({waddr(mcount, 2), in_ext});
                    exp_q.push_back({waddr(mcount, 3), in_hpos});
                    mcount++;
                end else begin
                    movf = 1;
                end
            end
            if (list_end && !mdone) begin
                for (int s = mcount; s < N; s++)
                    for (int b = 0; b < 4; b++)
                        exp_q.push_back({waddr(s, b), (b == 0) ? 8'hF8 : 8'h00});
                mdone = 1;
            end
        end
        @(posedge master_clk);
        #1;
        frame_start = 0;
        list_end = 0;
        if (hs) in_valid = 0;
        if (rnd_win) wr_window = ($urandom_range(0, 3) != 0);
        #1;
    endtask

    task automatic send_rec(input logic [31:0] r);
        {in_hpos, in_ext, in_idx, in_vpos} = r;
        in_valid = 1;
        for (int i = 0; i < 300 && in_valid; i++) step();
        if (in_valid) begin
            n_cmp++; n_bad++;
            $display("FAIL handshake_timeout: got no in_ready expected handshake (t=%0t)", $time);
            in_valid = 0;
        end
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
        chk("writes_outstanding", exp_q.size(), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, gap;
        bit ok;
        logic [31:0] rb;
        logic [18:0] exp_b[8];

        // Reset values, with the window already open
        repeat (3) @(posedge master_clk);
        #1; wr_window = 1; #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_spr_we", int'(spr_we), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_count", int'(sprite_count), 0);
        chk("rst_addr", int'(spr_addr), 0);
        chk("rst_data", int'(spr_data), 0);
        @(posedge master_clk); #1; reset = 0; #1;

        // Single record: four back-to-back writes, count and ready at T+5
        send_rec(32'h7F81_3310);
        chk("t1_busy", int'(busy), 1);
        chk("t1_we", int'(spr_we), 1);
        chk("t1_ready_low", int'(in_ready), 0);
        repeat (3) step();
        chk("t1_count_T4", int'(sprite_count), 0);
        chk("t1_ready_T4", int'(in_ready), 0);
        step();
        chk("t1_count_T5", int'(sprite_count), 1);
        chk("t1_ready_T5", int'(in_ready), 1);
        chk("t1_busy_T5", int'(busy), 0);

        // Window gap after byte 1 of slot 2
        send_rec($urandom);
        drain(20);
        send_rec($urandom);
        step(); step();
        wr_window = 0; #1;
        repeat (3) begin
            chk("t2_gap_we", int'(spr_we), 0);
            step();
        end
        wr_window = 1;
        drain(20);
        chk("t2_count", int'(sprite_count), 3);

        // End of list: blank slots 3..127
        list_end = 1;
        step();
        drain(600);
        chk("t3_count", int'(sprite_count), 3);
        in_valid = 1; #1;
        chk("t3_ready_done", int'(in_ready), 0);
        chk("t3_busy", int'(busy), 0);
        in_valid = 0;
        repeat (3) step();

        // Abort during byte 2 of record 5, together with list_end
        frame_start = 1;
        step();
        chk("t5_count_restart", int'(sprite_count), 0);
        repeat (5) send_rec($urandom);
        step(); step();
        frame_start = 1; list_end = 1; #1;
        chk("t5_abort_we", int'(spr_we), 0);
        step();
        chk("t5_count", int'(sprite_count), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_ready", int'(in_ready), 1);
        repeat (4) step();
        send_rec($urandom);
        drain(20);
        repeat (8) step();
        chk("t5_count_after", int'(sprite_count), 1);

        // list_end mid-record: clear follows the last byte with no gap
        send_rec($urandom);
        step();
        list_end = 1;
        step();
        gap = 0;
        for (int i = 0; i < 506; i++) begin
            if (!spr_we) gap++;
            step();
        end
        chk("t6_gapless", gap, 0);
        chk("t6_outstanding", exp_q.size(), 0);
        chk("t6_we_done", int'(spr_we), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_count", int'(sprite_count), 2);

        // Random frames with a flickering write window
        rnd_win = 1;
        for (int f = 0; f < 5; f++) begin
            frame_start = 1;
            step();
            n = (f == 1) ? 131 : int'($urandom_range(0, 140));
            for (int i = 0; i < n; i++) begin
                send_rec($urandom);
                if (i == N) chk("rnd_overflow_set", int'(overflow), 1);
            end
            list_end = 1;
            step();
            drain(5000);
            chk("rnd_count", int'(sprite_count), (n > N) ? N : n);
            chk("rnd_overflow", int'(overflow), (n > N) ? 1 : 0);
            chk("rnd_busy", int'(busy), 0);
        end
        rnd_win = 0;
        wr_window = 1;

        // Two-slot instance: wrap past 7FF, then overflow on the third record
        b_fs = 1; @(posedge master_clk); #2; b_fs = 0;
        for (int r = 0; r < 3; r++) begin
            rb = $urandom;
            {in_hpos, in_ext, in_idx, in_vpos} = rb;
            if (r < 2)
                for (int b = 0; b < 4; b++)
                    exp_b[r * 4 + b] = {11'h7FC + 11'(r * 4 + b), rb[b*8 +: 8]};
            b_valid = 1;
            ok = 0;
            for (int i = 0; i < 20 && !ok; i++) begin
                @(negedge master_clk); ok = b_ready;
                @(posedge master_clk); #2;
            end
            b_valid = 0;
            chk("b_accept", int'(ok), 1);
        end
        repeat (6) @(posedge master_clk);
        #2;
        chk("b_write_count", obs_b.size(), 8);
        for (int i = 0; i < 8 && i < obs_b.size(); i++)
            chk("b_write", int'(obs_b[i]), int'(exp_b[i]));
        chk("b_overflow", int'(b_ovf), 1);
        chk("b_count", int'(b_count), 2);
        chk("b_ready_full", int'(b_ready), 0);
        chk("b_busy", int'(b_busy), 0);
        b_fs = 1; @(posedge master_clk); #2; b_fs = 0;
        chk("b_overflow_clr", int'(b_ovf), 0);
        chk("b_count_clr", int'(b_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sprite_list_writer.md
# sprite_list_writer

Writer side of the mainboard sprite RAM. It accepts whole sprite records (vertical position, tile index, extra attributes, horizontal position) over a valid/ready stream and serialises each one into four byte writes on the sprite RAM CPU-side port. It then blanks every unused slot after the end of the list. It sits between the sprite-list source (CPU shadow copy or DMA) and the 2 KB sprite RAM that the sprite layer renderer scans. Writes happen only while the write window is open, so the renderer never sees a torn record.

## Interface

Parameters:
- `BASE_ADDR`, default 11'h000: sprite RAM byte address of slot 0.
- `N_SPRITES`, default 128: number of slots; 1..512, and `4*N_SPRITES` ≤ 2048.
- `BLANK_VPOS`, default 8'hF8: VPOS byte written to unused slots (off-screen).

Ports:
- `master_clk` in 1: sole clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `frame_start` in 1: one-cycle pulse; restarts the list.
- `list_end` in 1: one-cycle pulse; the list is complete, so blank the remaining slots.
- `wr_window` in 1: high = sprite RAM may be written.
- `in_valid` in 1: record valid.
- `in_ready` out 1: block accepts a record this cycle.
- `in_vpos`, `in_idx`, `in_ext`, `in_hpos` in 8 each: record fields. `in_ext[7]` = priority, `[2:1]` = palette, `[0]` = HPOS bit 8.
- `spr_addr` out 11: sprite RAM byte address.
- `spr_data` out 8: write data.
- `spr_we` out 1: active-high write strobe, one byte per cycle.
- `sprite_count` out 10: records written since the last `frame_start` (0..N_SPRITES).
- `busy` out 1: high in WRITE or CLEAR.
- `overflow` out 1: sticky; a record arrived while the list was full.

## Operation

States:
- **IDLE**: `in_ready = wr_window & (sprite_count < N_SPRITES)`.
  - On `in_valid & in_ready`, latch all four fields, set byte index to 0, go to WRITE.
  - If `in_valid` is high while the list is full and `wr_window` is high: accept (`in_ready` high for that cycle), discard the record, set `overflow`, stay in IDLE.
  - If `list_end` or pending-end is set: go to CLEAR, or straight to DONE when `sprite_count == N_SPRITES`.
- **WRITE**: byte order 0 = VPOS, 1 = IDX, 2 = EXT, 3 = HPOS.
  - `spr_addr = BASE_ADDR + 4*sprite_count + byte`, mod 2048.
  - `spr_we = wr_window`; the byte index advances only when `spr_we` is high.
  - After byte 3 is written, increment `sprite_count` and return to IDLE.
- **CLEAR**: a slot counter starts at `sprite_count`.
  - Each slot gets bytes BLANK_VPOS, 0, 0, 0 at the same address rule, one byte per cycle, and only while `wr_window` is high.
  - After the last byte of slot N_SPRITES-1 is written, go to DONE. `sprite_count` is not changed by CLEAR.
- **DONE**: `in_ready` = 0, `spr_we` = 0. Waits for `frame_start`.

Rules for `list_end`, `frame_start` and outputs:
- A `list_end` pulse received in WRITE sets a pending-end flag. The flag is consumed on entry to CLEAR or DONE.
- A `list_end` pulse received in CLEAR or DONE is ignored.
- `frame_start`, in any state, takes priority over `in_valid` and `list_end` in the same cycle. It:
  - aborts any in-flight record, which is dropped with no further writes;
  - sets `sprite_count` to 0;
  - clears `overflow` and pending-end;
  - puts the FSM in IDLE.
  - `spr_we` is 0 in that cycle.
- `spr_data` and `spr_addr` hold their last values when `spr_we` = 0.
- Reset values:
  - state IDLE;
  - `spr_we`, `in_ready`, `busy`, `overflow` = 0;
  - `sprite_count` = 0;
  - `spr_addr` = BASE_ADDR;
  - `spr_data` = 0.
  - `in_ready` may rise only in the cycle after reset is released.

## Timing

- Handshake at edge T:
  - `spr_we` is high for cycles T+1..T+4 with `wr_window` high throughout.
  - `sprite_count` updates at edge T+4.
  - `in_ready` is high again in cycle T+5.
  - Throughput is 1 record per 5 cycles.
- `wr_window` low in WRITE or CLEAR: `spr_we` drops in the same cycle (combinational gate on a registered state). Byte index and address hold, and the sequence resumes on the same byte.
- `in_ready` is low during WRITE, CLEAR and DONE, and whenever `wr_window` is low.
- CLEAR with k free slots takes exactly `4k` window-open cycles.
- `busy` is registered and high from the cycle after acceptance, or after entry to CLEAR, until the final byte write completes.

## Test plan

1. **Single record:** after reset, assert `wr_window`; send vpos=10, idx=33, ext=81, hpos=7F.
   - Expect writes 000←10, 001←33, 002←81, 003←7F in 4 consecutive cycles.
   - Then `sprite_count` = 1 and `in_ready` high 5 cycles after the handshake.
2. **Window gap:** drop `wr_window` for 3 cycles after byte 1 of a record at slot 2.
   - Expect writes at 008, 009, then no `spr_we` for 3 cycles, then 00A and 00B.
   - No byte is duplicated or skipped.
3. **Clear:** send 3 records, then pulse `list_end` (N_SPRITES = 128).
   - Expect 500 blank writes from 00C to 1FF: F8 at every address ≡ 0 mod 4, 00 elsewhere.
   - Then DONE with `in_ready` = 0.
4. **Overflow:** with N_SPRITES = 2, send 3 records.
   - Third record: `in_ready` high, no `spr_we`, `overflow` = 1.
   - `frame_start` clears `overflow` and `sprite_count`.
5. **Abort:** pulse `frame_start` during byte 2 of record 5, together with `list_end`.
   - Expect no further writes and `sprite_count` = 0.
   - Next accepted record writes 000..003; no CLEAR occurs.
6. **List_end during WRITE:** pulse `list_end` while a record is being written.
   - Record completes; CLEAR starts the cycle after its last byte.
   - The first blank byte goes to that record's slot + 1.
